// File: rtl/imem_refill.sv
// imem_refill: instruction-memory refill engine with a fixed-latency backing store.
// An instruction-cache refill request (level-held req + req_addr) is accepted in
// IDLE. After MEM_LATENCY cycles the addressed line is registered onto data_out
// and data_rdy is raised. data_rdy is held until req drops. A preload port writes
// lines into the store in any state.
//
// Optional build macro: IMEM_ADDR_CHECK_EN
//   defined   - an accepted address >= MEM_NLINES returns zero data with a one-cycle
//               err pulse; out-of-range preloads are dropped.
//   undefined - addresses wrap modulo MEM_NLINES; err is tied low.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   req, req_addr      refill request (level-held) and line address
//   ld_en/addr/data    preload write strobe, line address, line data
//   data_rdy, data_out refill data valid (held while req) and line data
//   busy               state != IDLE (combinational decode)
//   err                out-of-range pulse (check builds only)
module imem_refill #(
    parameter int unsigned LINE_W      = 128,
    parameter int unsigned ADDR_W      = 26,
    parameter int unsigned MEM_NLINES  = 256,
    parameter int unsigned MEM_LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [LINE_W-1:0] ld_data,
    output logic              data_rdy,
    output logic [LINE_W-1:0] data_out,
    output logic              busy,
    output logic              err
);

    localparam int unsigned IDX_W    = (MEM_NLINES > 1) ? $clog2(MEM_NLINES) : 1;
    localparam int unsigned CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                data_rdy_q, data_rdy_d;
    logic [LINE_W-1:0]   data_out_q, data_out_d;

    logic [LINE_W-1:0]   mem [MEM_NLINES];
    logic [LINE_W-1:0]   rd_data;
    logic                ld_we;

    // Line index: address modulo store depth (works for non-power-of-two depths).
    function automatic logic [IDX_W-1:0] line_idx(input logic [ADDR_W-1:0] a);
        line_idx = IDX_W'(a % ADDR_W'(MEM_NLINES));
    endfunction

`ifdef IMEM_ADDR_CHECK_EN
    logic err_q, err_d;
    logic rd_oor;

    assign rd_oor  = (addr_q >= ADDR_W'(MEM_NLINES));
    assign ld_we   = ld_en && (ld_addr < ADDR_W'(MEM_NLINES));
    assign rd_data = rd_oor ? '0 : mem[line_idx(addr_q)];
    assign err     = err_q;
`else
    assign ld_we   = ld_en;
    assign rd_data = mem[line_idx(addr_q)];
    assign err     = 1'b0;
`endif

    // Backing store: not reset, so preloaded contents survive a reset.
    // Reads sample the pre-edge contents, so a same-edge preload returns old data.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[line_idx(ld_addr)] <= ld_data;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_rdy_q <= 1'b0;
            data_out_q <= '0;
`ifdef IMEM_ADDR_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_rdy_q <= data_rdy_d;
            data_out_q <= data_out_d;
`ifdef IMEM_ADDR_CHECK_EN
            err_q      <= err_d;
`endif
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_rdy_d = data_rdy_q;
        data_out_d = data_out_q;
`ifdef IMEM_ADDR_CHECK_EN
        err_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = req_addr;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!req) begin
                    // Abort: no response, data_out keeps the previous line.
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    data_out_d = rd_data;
                    data_rdy_d = 1'b1;
                    state_d    = RESP;
`ifdef IMEM_ADDR_CHECK_EN
                    err_d      = rd_oor;
`endif
                end
            end
            RESP: begin
                if (!req) begin
                    data_rdy_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_rdy = data_rdy_q;
    assign data_out = data_out_q;
    assign busy     = (state_q != IDLE);

endmodule
